// File: rtl/ram_arb.sv
// ram_arb: two-port arbiter/sequencer in front of the single PSRAM request port.
// Port A (DCJ11 bus cycles) has fixed priority. Port B (host DMA) is forced in
// after STARVE_MAX consecutive A grants made while B was waiting. Each grant
// issues one memory op and returns rdata, or a timeout error, to its owner.
module ram_arb #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_byte,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  output logic              a_ack,
  output logic [15:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_byte,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_wdata,
  output logic              b_ack,
  output logic [15:0]       b_rdata,
  output logic              err,
  output logic              busy,
  input  logic              mem_init,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_done
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t              state_q;
  logic                owner_b_q;
  logic                we_q;
  logic [2:0]          starve_q;
  logic [7:0]          tmo_q;
  logic                a_ack_q, b_ack_q, err_q, busy_q;
  logic                mem_rd_q, mem_wr_q, mem_byte_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [15:0]         mem_wdata_q;
  logic [15:0]         a_rdata_q, b_rdata_q;

  logic                grant_d;
  logic                b_win_d;
  logic [2:0]          starve_d;

  // Winner selection and starvation-counter next value, evaluated in IDLE.
  always_comb begin
    grant_d  = mem_init && (a_req || b_req);
    b_win_d  = b_req && (!a_req || (starve_q == STARVE_LIM));
    starve_d = '0;
    if (!b_win_d && b_req) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 3'd1;
    end
  end

  // Sequencer: IDLE -> ISSUE -> WAIT -> ACK, all outputs registered.
  // The strobe is registered on the granting edge so it is high exactly while
  // the FSM sits in ISSUE; err_q doubles as the timeout flag for the ACK cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_b_q   <= 1'b0;
      we_q        <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      err_q    <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_d) begin
            owner_b_q   <= b_win_d;
            we_q        <= b_win_d ? b_we : a_we;
            mem_byte_q  <= b_win_d ? b_byte : a_byte;
            mem_addr_q  <= b_win_d ? b_addr : a_addr;
            mem_wdata_q <= b_win_d ? b_wdata : a_wdata;
            mem_rd_q    <= b_win_d ? !b_we : !a_we;
            mem_wr_q    <= b_win_d ? b_we : a_we;
            starve_q    <= starve_d;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_done) begin
            if (!we_q) begin
              if (owner_b_q) b_rdata_q <= mem_rdata;
              else           a_rdata_q <= mem_rdata;
            end
            a_ack_q <= !owner_b_q;
            b_ack_q <= owner_b_q;
            state_q <= S_ACK;
          end else if (tmo_q == TMO_LIM) begin
            if (!we_q) begin
              if (owner_b_q) b_rdata_q <= 16'hFFFF;
              else           a_rdata_q <= 16'hFFFF;
            end
            a_ack_q <= !owner_b_q;
            b_ack_q <= owner_b_q;
            err_q   <= 1'b1;
            state_q <= S_ACK;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_ACK: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_byte  = mem_byte_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_arb.sv
// Scoreboard bench for ram_arb: a behavioural PSRAM responder, an ack monitor
// that pops expected completions, and directed timing checks per access.
module tb_ram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, a_byte;
  logic [21:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_ack;
  logic [15:0] a_rdata;
  logic        b_req, b_we, b_byte;
  logic [21:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic        err, busy, mem_init;
  logic        mem_rd, mem_wr, mem_byte;
  logic [21:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;

  ram_arb #(.ADDR_W(22), .STARVE_MAX(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_byte(a_byte), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_byte(b_byte), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .err(err), .busy(busy), .mem_init(mem_init),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic        port_b;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [logic [21:0]];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ack_cnt = 0;
  logic [15:0] exp_a = '0;
  logic [15:0] exp_b = '0;
  bit          resp_en = 1'b1;
  int          resp_dly = 2;
  bit          inj_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_val(input logic [21:0] addr);
    if (model.exists(addr)) return model[addr];
    return addr[15:0] ^ 16'h5A5A;
  endfunction

  // Behavioural PSRAM: answers each strobe resp_dly cycles later; inj_req
  // forces one spurious mem_done pulse.
  task automatic responder();
    int          pend = 0;
    logic [15:0] pdata = '0;
    forever begin
      @(negedge clk); #2;
      mem_done = 1'b0;
      if (rst) begin
        pend = 0;
      end else if (inj_req) begin
        mem_done  = 1'b1;
        mem_rdata = 16'hBEEF;
        inj_req   = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_done  = 1'b1;
          mem_rdata = pdata;
        end
      end
      if (!rst && (mem_rd || mem_wr) && resp_en) begin
        if (mem_wr) model[mem_addr] = mem_wdata;
        pdata = mem_rd ? mem_val(mem_addr) : 16'hDEAD;
        pend  = resp_dly;
      end
    end
  endtask

  // Pops the scoreboard on every ack and checks strobe shape.
  task automatic monitor();
    exp_t it;
    bit   prev_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        ack_cnt++;
        if (sb.size() == 0) begin
          chk("ack_unexpected", 32'({b_ack, a_ack}), 32'd0);
        end else begin
          it = sb.pop_front();
          chk("ack_port", 32'({b_ack, a_ack}), it.port_b ? 32'd2 : 32'd1);
          chk("ack_rdata", 32'(it.port_b ? b_rdata : a_rdata), 32'(it.rdata));
          chk("ack_err", 32'(err), 32'(it.err));
        end
      end else if (err) begin
        chk("err_without_ack", 32'(err), 32'd0);
      end
      if (mem_rd || mem_wr) begin
        chk("strobe_width", 32'(prev_stb), 32'd0);
        chk("strobe_excl", 32'(mem_rd & mem_wr), 32'd0);
      end
      prev_stb = mem_rd || mem_wr;
    end
  endtask

  // One access with latency check; init_lo cycles are spent with mem_init low.
  task automatic do_access(input bit pb, input bit we, input bit bt,
                           input logic [21:0] addr, input logic [15:0] wd,
                           input int ack_cyc, input bit exp_e, input int init_lo);
    exp_t        it;
    logic [15:0] exp_rd;
    int          got;
    bit          ack;
    exp_rd = pb ? exp_b : exp_a;
    if (!we) exp_rd = exp_e ? 16'hFFFF : mem_val(addr);
    if (pb) exp_b = exp_rd;
    else    exp_a = exp_rd;
    it.port_b = pb; it.rdata = exp_rd; it.err = exp_e;
    sb.push_back(it);
    if (init_lo > 0) mem_init = 1'b0;
    if (pb) begin
      b_req = 1'b1; b_we = we; b_byte = bt; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_byte = bt; a_addr = addr; a_wdata = wd;
    end
    for (int i = 0; i < init_lo; i++) begin
      @(negedge clk);
      chk("init_lo_strobe", 32'({mem_rd, mem_wr}), 32'd0);
      chk("init_lo_busy", 32'(busy), 32'd0);
    end
    mem_init = 1'b1;
    got = -1;
    for (int i = 1; i <= ack_cyc + 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("strobe_kind", 32'({mem_wr, mem_rd}), we ? 32'd2 : 32'd1);
        chk("strobe_addr", 32'(mem_addr), 32'(addr));
        chk("strobe_byte", 32'(mem_byte), 32'(bt));
        if (we) chk("strobe_wdata", 32'(mem_wdata), 32'(wd));
      end
      ack = pb ? b_ack : a_ack;
      if (ack) begin
        got = i;
        break;
      end
    end
    chk("ack_latency", 32'(got), 32'(ack_cyc));
    if (pb) b_req = 1'b0;
    else    a_req = 1'b0;
  endtask

  initial begin
    int   base;
    exp_t it;
    rst = 1'b1; mem_init = 1'b1;
    a_req = 0; a_we = 0; a_byte = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_byte = 0; b_addr = '0; b_wdata = '0;
    mem_done = 1'b0; mem_rdata = '0;
    model[22'o00001000] = 16'o123456;
    model[22'o00002000] = 16'h1234;
    fork
      responder();
      monitor();
      begin
        #200000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({a_ack, b_ack, err, busy, mem_rd, mem_wr, mem_byte}), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // A read, memory answers two cycles after the strobe
    resp_dly = 2;
    do_access(1'b0, 1'b0, 1'b0, 22'o00001000, 16'h0000, 4, 1'b0, 0);
    @(negedge clk);
    // A byte write; a_rdata must stay at the previous read value
    do_access(1'b0, 1'b1, 1'b1, 22'o17757776, 16'h00A5, 4, 1'b0, 0);
    @(negedge clk);

    // Both ports held: A,A,A,A,B,A,A,A,A,B
    resp_dly = 1;
    for (int g = 0; g < 10; g++) begin
      it.port_b = (g % 5 == 4);
      it.rdata  = it.port_b ? mem_val(22'o00002000) : mem_val(22'o00001000);
      it.err    = 1'b0;
      sb.push_back(it);
    end
    exp_a = mem_val(22'o00001000);
    exp_b = mem_val(22'o00002000);
    base = ack_cnt;
    a_req = 1; a_we = 0; a_byte = 0; a_addr = 22'o00001000;
    b_req = 1; b_we = 0; b_byte = 0; b_addr = 22'o00002000;
    for (int i = 0; i < 200 && ack_cnt < base + 10; i++) begin
      @(negedge clk); #1;
    end
    a_req = 0; b_req = 0;
    chk("starve_acks", 32'(ack_cnt - base), 32'd10);
    repeat (4) @(negedge clk);

    // B read timeout, then a stale completion must be ignored
    resp_en = 1'b0;
    do_access(1'b1, 1'b0, 1'b0, 22'o00003000, 16'h0000, 258, 1'b1, 0);
    repeat (2) @(negedge clk);
    base = ack_cnt;
    inj_req = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("stale_done_ack", 32'(ack_cnt - base), 32'd0);
    chk("stale_done_busy", 32'(busy), 32'd0);

    // Reset while waiting on memory
    a_req = 1; a_we = 0; a_byte = 0; a_addr = 22'o00001000; a_wdata = 16'h00A5;
    resp_dly = 2;
    repeat (3) @(negedge clk);
    chk("wait_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1; a_req = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'({a_ack, b_ack, err, busy, mem_rd, mem_wr, mem_byte}), 32'd0);
    chk("async_rst_addr", 32'(mem_addr), 32'd0);
    chk("async_rst_wdata", 32'(mem_wdata), 32'd0);
    chk("async_rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    exp_a = '0; exp_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = ack_cnt;
    inj_req = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("post_rst_no_ack", 32'(ack_cnt - base), 32'd0);
    resp_en = 1'b1;
    do_access(1'b0, 1'b0, 1'b0, 22'o00001000, 16'h0000, 4, 1'b0, 0);
    @(negedge clk);

    // mem_init low for 20 cycles, then release
    do_access(1'b0, 1'b0, 1'b0, 22'o00002000, 16'h0000, 4, 1'b0, 20);
    repeat (4) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
